// File: rtl/cfg_arbiter.sv
// ---------------------------------------------------------------------------
// cfg_arbiter
//
// Two-port round-robin arbiter in front of a single-cycle config register
// file. Each cycle at most one request (from port A or B) is accepted and
// turned into a registered write or read strobe on the cfg_* bus. Reads are
// returned to the originating port through a held rsp_valid/rsp_data
// handshake. A port with an unacknowledged read is not eligible for grants
// until its response has been taken, but it never blocks the other port.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   {a,b}_req_valid/wr/addr/data   request from port A / B
//   {a,b}_req_ready                request accepted this cycle (combinational)
//   {a,b}_rsp_valid/data           read response (registered, held)
//   {a,b}_rsp_ready                response consumed by the requester
//   cfg_wr_en/addr/data            write strobe to the register file
//   cfg_rd_en/addr                 read strobe to the register file
//   cfg_rd_data                    read data, valid one cycle after cfg_rd_en
// ---------------------------------------------------------------------------
module cfg_arbiter #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // port A
  input  logic                  a_req_valid,
  input  logic                  a_req_wr,
  input  logic [CFG_AWIDTH-1:0] a_req_addr,
  input  logic [CFG_DWIDTH-1:0] a_req_data,
  output logic                  a_req_ready,
  output logic                  a_rsp_valid,
  output logic [CFG_DWIDTH-1:0] a_rsp_data,
  input  logic                  a_rsp_ready,
  // port B
  input  logic                  b_req_valid,
  input  logic                  b_req_wr,
  input  logic [CFG_AWIDTH-1:0] b_req_addr,
  input  logic [CFG_DWIDTH-1:0] b_req_data,
  output logic                  b_req_ready,
  output logic                  b_rsp_valid,
  output logic [CFG_DWIDTH-1:0] b_rsp_data,
  input  logic                  b_rsp_ready,
  // config register file
  output logic                  cfg_wr_en,
  output logic [CFG_AWIDTH-1:0] cfg_wr_addr,
  output logic [CFG_DWIDTH-1:0] cfg_wr_data,
  output logic                  cfg_rd_en,
  output logic [CFG_AWIDTH-1:0] cfg_rd_addr,
  input  logic [CFG_DWIDTH-1:0] cfg_rd_data
);

  localparam int   NP     = 2;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Port-indexed views of the two requester interfaces (index 0 = A, 1 = B)
  logic [NP-1:0]         req_valid;
  logic [NP-1:0]         req_wr;
  logic [NP-1:0]         rsp_ready;
  logic [CFG_AWIDTH-1:0] req_addr [NP];
  logic [CFG_DWIDTH-1:0] req_data [NP];
  logic [NP-1:0]         rsp_valid;
  logic [CFG_DWIDTH-1:0] rsp_data [NP];

  assign req_valid   = {b_req_valid, a_req_valid};
  assign req_wr      = {b_req_wr,    a_req_wr};
  assign rsp_ready   = {b_rsp_ready, a_rsp_ready};
  assign req_addr[0] = a_req_addr;
  assign req_addr[1] = b_req_addr;
  assign req_data[0] = a_req_data;
  assign req_data[1] = b_req_data;

  // Arbitration
  logic [NP-1:0]         eligible;
  logic [NP-1:0]         grant;
  logic                  grant_any;
  logic                  grant_port;
  logic                  sel_wr;
  logic [CFG_AWIDTH-1:0] sel_addr;
  logic [CFG_DWIDTH-1:0] sel_data;
  logic                  last_grant_reg;
  logic                  last_grant_next;

  always_comb begin
    grant = '0;
    if (!rst) begin
      if (&eligible) begin
        // Tie: favour the port that did not win the previous grant
        grant = (last_grant_reg == PORT_B) ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
  end

  assign grant_any       = |grant;
  assign grant_port      = grant[1];
  assign sel_wr          = req_wr[grant_port];
  assign sel_addr        = req_addr[grant_port];
  assign sel_data        = req_data[grant_port];
  assign last_grant_next = grant_any ? grant_port : last_grant_reg;

  assign a_req_ready = grant[0];
  assign b_req_ready = grant[1];

  // Strobe generation and read-return pipeline.
  // rd_port_reg travels with cfg_rd_en; ret_valid_reg/ret_port_reg mark the
  // cycle in which cfg_rd_data is valid and which port it belongs to.
  logic                  wr_en_reg;
  logic [CFG_AWIDTH-1:0] wr_addr_reg;
  logic [CFG_DWIDTH-1:0] wr_data_reg;
  logic                  rd_en_reg;
  logic [CFG_AWIDTH-1:0] rd_addr_reg;
  logic                  rd_port_reg;
  logic                  ret_valid_reg;
  logic                  ret_port_reg;
  logic                  wr_fire;
  logic                  rd_fire;

  assign wr_fire = grant_any & sel_wr;
  assign rd_fire = grant_any & ~sel_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= PORT_B;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      rd_en_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      rd_port_reg    <= PORT_A;
      ret_valid_reg  <= 1'b0;
      ret_port_reg   <= PORT_A;
    end else begin
      last_grant_reg <= last_grant_next;
      wr_en_reg      <= wr_fire;
      wr_addr_reg    <= wr_fire ? sel_addr : '0;
      if (wr_fire) begin
        wr_data_reg <= sel_data;  // data bus keeps its last value when idle
      end
      rd_en_reg      <= rd_fire;
      rd_addr_reg    <= rd_fire ? sel_addr : '0;
      rd_port_reg    <= grant_port;
      ret_valid_reg  <= rd_en_reg;
      ret_port_reg   <= rd_port_reg;
    end
  end

  assign cfg_wr_en   = wr_en_reg;
  assign cfg_wr_addr = wr_addr_reg;
  assign cfg_wr_data = wr_data_reg;
  assign cfg_rd_en   = rd_en_reg;
  assign cfg_rd_addr = rd_addr_reg;

  // Per-port response holding register and busy flag
  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    logic                  busy_reg;
    logic                  rsp_valid_reg;
    logic [CFG_DWIDTH-1:0] rsp_data_reg;
    logic                  rsp_done;
    logic                  rd_return;

    assign eligible[gi] = req_valid[gi] & ~busy_reg;
    assign rsp_done     = rsp_valid_reg & rsp_ready[gi];
    assign rd_return    = ret_valid_reg & (ret_port_reg == 1'(gi));

    // A port can only have one read outstanding, so a return never collides
    // with a handshake on the same port.
    always_ff @(posedge clk) begin
      if (rst) begin
        busy_reg      <= 1'b0;
        rsp_valid_reg <= 1'b0;
        rsp_data_reg  <= '0;
      end else begin
        if (rsp_done) begin
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
        if (rd_return) begin
          rsp_valid_reg <= 1'b1;
          rsp_data_reg  <= cfg_rd_data;
        end
        if (grant[gi] & ~req_wr[gi]) begin
          busy_reg <= 1'b1;
        end
      end
    end

    assign rsp_valid[gi] = rsp_valid_reg;
    assign rsp_data[gi]  = rsp_data_reg;
  end

  assign a_rsp_valid = rsp_valid[0];
  assign b_rsp_valid = rsp_valid[1];
  assign a_rsp_data  = rsp_data[0];
  assign b_rsp_data  = rsp_data[1];

endmodule

// File: tb/tb_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cfg_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level
// model (grant order, register-file contents, per-port response timing)
// predicts every DUT output each cycle. A small register-file environment
// answers cfg_rd_en with the stored word one cycle later and drives junk
// on cfg_rd_data otherwise.
// ---------------------------------------------------------------------------
module tb_cfg_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NCYC = 2000;

  localparam int M_IDLE = 0;
  localparam int M_WR   = 1;
  localparam int M_RD   = 2;
  localparam int M_RAND = 3;
  localparam int M_FIX  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req_valid, a_req_wr, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_data, a_rsp_data;
  logic          b_req_valid, b_req_wr, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_data, b_rsp_data;
  logic          cfg_wr_en, cfg_rd_en;
  logic [AW-1:0] cfg_wr_addr, cfg_rd_addr;
  logic [DW-1:0] cfg_wr_data, cfg_rd_data;

  cfg_arbiter #(.CFG_DWIDTH(DW), .CFG_AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_wr(a_req_wr), .a_req_addr(a_req_addr),
    .a_req_data(a_req_data), .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid),
    .a_rsp_data(a_rsp_data), .a_rsp_ready(a_rsp_ready),
    .b_req_valid(b_req_valid), .b_req_wr(b_req_wr), .b_req_addr(b_req_addr),
    .b_req_data(b_req_data), .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid),
    .b_rsp_data(b_rsp_data), .b_rsp_ready(b_rsp_ready),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Requester stimulus state (index 0 = A, 1 = B)
  logic          rq_valid [2];
  logic          rq_wr    [2];
  logic [AW-1:0] rq_addr  [2];
  logic [DW-1:0] rq_data  [2];
  logic          rq_pend  [2];
  logic          rsp_rdy  [2];
  int            mode     [2];
  logic          fix_wr   [2];
  logic [AW-1:0] fix_addr [2];
  logic [DW-1:0] fix_data [2];

  // Register-file environment
  logic [DW-1:0] env_rf [32];
  logic          env_rd_pend;
  logic [AW-1:0] env_rd_addr;

  // Reference model
  logic [DW-1:0] m_mem      [32];
  logic          m_last;                 // 0 = A, 1 = B
  logic          m_busy     [2];
  int            m_cnt      [2];
  logic [DW-1:0] m_ret_data [2];
  logic          m_rsp_valid[2];
  logic [DW-1:0] m_rsp_data [2];
  logic          e_wr_en, e_rd_en;
  logic [AW-1:0] e_wr_addr, e_rd_addr;
  logic [DW-1:0] e_wr_data;

  task automatic model_reset();
    m_last = 1'b1;
    for (int p = 0; p < 2; p++) begin
      m_busy[p] = 0; m_cnt[p] = 0; m_rsp_valid[p] = 0; m_rsp_data[p] = '0;
    end
    e_wr_en = 0; e_rd_en = 0; e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0;
  endtask

  task automatic plan_cycle();
    for (int p = 0; p < 2; p++) begin
      mode[p] = M_IDLE; rsp_rdy[p] = 1'b1;
    end
    rst = (cyc < 3) || (cyc == 63) || (cyc >= 70 && $urandom_range(0, 255) == 0);
    if (cyc == 3)  begin mode[0] = M_FIX; fix_wr[0] = 1; fix_addr[0] = 3; fix_data[0] = 32'hDEADBEEF; end
    if (cyc == 6)  begin mode[0] = M_FIX; fix_wr[0] = 0; fix_addr[0] = 5; fix_data[0] = '0; end
    if (cyc >= 6 && cyc <= 11) rsp_rdy[0] = 1'b0;
    if (cyc >= 15 && cyc <= 26) begin mode[0] = M_WR; mode[1] = M_WR; end
    if (cyc >= 29 && cyc <= 45) begin mode[0] = M_RD; mode[1] = M_WR; end
    if (cyc >= 29 && cyc <= 41) rsp_rdy[0] = 1'b0;
    if (cyc == 51) begin mode[0] = M_FIX; fix_wr[0] = 0; fix_addr[0] = 7; end
    if (cyc == 52) begin mode[1] = M_FIX; fix_wr[1] = 0; fix_addr[1] = 9; end
    if (cyc == 62) begin mode[0] = M_FIX; fix_wr[0] = 0; fix_addr[0] = 11; end
    if (cyc == 68) begin mode[0] = M_FIX; fix_wr[0] = 1; fix_addr[0] = 11; fix_data[0] = 32'h600DF00D; end
    if (cyc == 69) begin mode[0] = M_FIX; fix_wr[0] = 0; fix_addr[0] = 11; end
    if (cyc >= 70) begin
      mode[0] = M_RAND; mode[1] = M_RAND;
      rsp_rdy[0] = ($urandom_range(0, 3) != 0);
      rsp_rdy[1] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < 2; p++) begin
      if (!rq_pend[p]) begin
        rq_valid[p] = 0; rq_wr[p] = 0; rq_addr[p] = '0; rq_data[p] = $urandom;
        case (mode[p])
          M_WR:   begin rq_valid[p] = 1; rq_wr[p] = 1; rq_addr[p] = AW'($urandom); end
          M_RD:   begin rq_valid[p] = 1; rq_wr[p] = 0; rq_addr[p] = AW'($urandom); end
          M_RAND: begin
            rq_valid[p] = ($urandom_range(0, 9) < 6);
            rq_wr[p]    = $urandom_range(0, 1) != 0;
            rq_addr[p]  = AW'($urandom);
          end
          M_FIX:  begin
            rq_valid[p] = 1; rq_wr[p] = fix_wr[p]; rq_addr[p] = fix_addr[p]; rq_data[p] = fix_data[p];
          end
          default: ;
        endcase
        rq_pend[p] = rq_valid[p];
      end
    end
    a_req_valid = rq_valid[0]; a_req_wr = rq_wr[0]; a_req_addr = rq_addr[0]; a_req_data = rq_data[0];
    b_req_valid = rq_valid[1]; b_req_wr = rq_wr[1]; b_req_addr = rq_addr[1]; b_req_data = rq_data[1];
    a_rsp_ready = rsp_rdy[0];
    b_rsp_ready = rsp_rdy[1];
    cfg_rd_data = env_rd_pend ? env_rf[env_rd_addr] : $urandom;
  endtask

  task automatic check_and_step();
    int  g;
    logic el0, el1;
    // Expected grant from the arbitration rules
    g = -1;
    el0 = rq_valid[0] && !m_busy[0];
    el1 = rq_valid[1] && !m_busy[1];
    if (!rst) begin
      if (el0 && el1) g = m_last ? 0 : 1;
      else if (el0)   g = 0;
      else if (el1)   g = 1;
    end
    check_val("a_req_ready", a_req_ready, g == 0);
    check_val("b_req_ready", b_req_ready, g == 1);
    check_val("cfg_wr_en",   cfg_wr_en,   e_wr_en);
    check_val("cfg_wr_addr", cfg_wr_addr, e_wr_addr);
    check_val("cfg_wr_data", cfg_wr_data, e_wr_data);
    check_val("cfg_rd_en",   cfg_rd_en,   e_rd_en);
    check_val("cfg_rd_addr", cfg_rd_addr, e_rd_addr);
    check_val("a_rsp_valid", a_rsp_valid, m_rsp_valid[0]);
    check_val("a_rsp_data",  a_rsp_data,  m_rsp_data[0]);
    check_val("b_rsp_valid", b_rsp_valid, m_rsp_valid[1]);
    check_val("b_rsp_data",  b_rsp_data,  m_rsp_data[1]);

    // Register-file environment reacts to the strobes it sees
    if (cfg_wr_en === 1'b1) env_rf[cfg_wr_addr] = cfg_wr_data;
    env_rd_pend = (cfg_rd_en === 1'b1);
    env_rd_addr = cfg_rd_addr;

    // Advance the model to the next cycle
    if (rst) begin
      model_reset();
      if (cyc >= 3) $display("cycle %0d reset", cyc);
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (m_rsp_valid[p] && rsp_rdy[p]) begin
          m_rsp_valid[p] = 0; m_busy[p] = 0;
        end
        if (m_cnt[p] > 0) begin
          m_cnt[p]--;
          if (m_cnt[p] == 0) begin
            m_rsp_valid[p] = 1; m_rsp_data[p] = m_ret_data[p];
          end
        end
      end
      e_wr_en = 0; e_wr_addr = '0; e_rd_en = 0; e_rd_addr = '0;
      if (g >= 0) begin
        m_last = (g == 1);
        rq_pend[g] = 0;
        if (rq_wr[g]) begin
          e_wr_en = 1; e_wr_addr = rq_addr[g]; e_wr_data = rq_data[g];
          m_mem[rq_addr[g]] = rq_data[g];
          $display("cycle %0d grant %s write addr %0d data %h", cyc, g ? "B" : "A", rq_addr[g], rq_data[g]);
        end else begin
          e_rd_en = 1; e_rd_addr = rq_addr[g];
          m_busy[g] = 1; m_cnt[g] = 2; m_ret_data[g] = m_mem[rq_addr[g]];
          $display("cycle %0d grant %s read addr %0d expect %h", cyc, g ? "B" : "A", rq_addr[g], m_ret_data[g]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      env_rf[i] = (32'h01010101 * i) ^ 32'h5A5A0000;
      m_mem[i]  = env_rf[i];
    end
    env_rf[5] = 32'h12345678;
    m_mem[5]  = 32'h12345678;
    for (int p = 0; p < 2; p++) begin
      rq_pend[p] = 0; rq_valid[p] = 0; rq_wr[p] = 0; rq_addr[p] = '0; rq_data[p] = '0;
      fix_wr[p] = 0; fix_addr[p] = '0; fix_data[p] = '0; rsp_rdy[p] = 1; mode[p] = M_IDLE;
    end
    env_rd_pend = 0; env_rd_addr = '0;
    rst = 1'b1;
    a_req_valid = 0; a_req_wr = 0; a_req_addr = '0; a_req_data = '0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_wr = 0; b_req_addr = '0; b_req_data = '0; b_rsp_ready = 0;
    cfg_rd_data = '0;
    model_reset();
    @(posedge clk);
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      plan_cycle();
      drive_inputs();
      @(negedge clk);
      check_and_step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
